// File: rtl/seq_stim_driver.sv
// On-chip stimulus/response driver: resets a two-input sequential DUT, steps {a,b} through a pattern,
// and counts high cycles on the DUT outputs. Define SEQ_STIM_LFSR_EN to drive {a,b} from a 4-bit LFSR.
module seq_stim_driver #(
    parameter int RST_CYCLES  = 2,
    parameter int HOLD_CYCLES = 2,
    parameter int NUM_STEPS   = 4,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start_in,
    input  logic             pause_in,
    input  logic             y1_in,
    input  logic             y2_in,
    output logic             dut_reset_n_out,
    output logic             a_out,
    output logic             b_out,
    output logic [1:0]       step_out,
    output logic             busy_out,
    output logic             done_out,
    output logic [CNT_W-1:0] y1_cnt_out,
    output logic [CNT_W-1:0] y2_cnt_out
);
    // One timer serves both the reset phase and the per-step hold.
    localparam int TMAX = (RST_CYCLES > HOLD_CYCLES) ? RST_CYCLES : HOLD_CYCLES;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam int SW   = (NUM_STEPS > 4) ? $clog2(NUM_STEPS) : 2;

    typedef enum logic [1:0] {S_IDLE, S_RST, S_RUN, S_DONE} state_t;

    state_t          state;
    logic [TW-1:0]   tmr;
    logic [SW-1:0]   step_q;
    logic [SW-1:0]   step_nxt;
    logic [CNT_W-1:0] y1_cnt;
    logic [CNT_W-1:0] y2_cnt;

    assign step_nxt   = step_q + SW'(1);
    assign step_out   = step_q[1:0];
    assign y1_cnt_out = y1_cnt;
    assign y2_cnt_out = y2_cnt;

`ifdef SEQ_STIM_LFSR_EN
    localparam logic [3:0] LFSR_SEED = 4'b1001;
    logic [3:0] lfsr;
    logic [3:0] lfsr_nxt;
    // x^4 + x^3 + 1, Fibonacci form shifting toward the MSB.
    assign lfsr_nxt = {lfsr[2:0], lfsr[3] ^ lfsr[2]};
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= S_IDLE;
            tmr             <= '0;
            step_q          <= '0;
            y1_cnt          <= '0;
            y2_cnt          <= '0;
            dut_reset_n_out <= 1'b0;
            a_out           <= 1'b0;
            b_out           <= 1'b0;
            busy_out        <= 1'b0;
            done_out        <= 1'b0;
`ifdef SEQ_STIM_LFSR_EN
            lfsr            <= LFSR_SEED;
`endif
        end else begin
            done_out <= 1'b0;
            case (state)
                S_IDLE: begin
                    dut_reset_n_out <= 1'b0;
                    if (start_in) begin
                        state    <= S_RST;
                        busy_out <= 1'b1;
                        y1_cnt   <= '0;
                        y2_cnt   <= '0;
                        step_q   <= '0;
                        tmr      <= '0;
`ifdef SEQ_STIM_LFSR_EN
                        lfsr     <= LFSR_SEED;
`endif
                    end
                end
                S_RST: begin
                    if (tmr == TW'(RST_CYCLES - 1)) begin
                        state           <= S_RUN;
                        tmr             <= '0;
                        dut_reset_n_out <= 1'b1;
`ifdef SEQ_STIM_LFSR_EN
                        {a_out, b_out}  <= lfsr[1:0];
`else
                        {a_out, b_out}  <= step_q[1:0];
`endif
                    end else begin
                        tmr <= tmr + TW'(1);
                    end
                end
                S_RUN: begin
                    // A paused cycle neither advances the sequence nor counts toward the monitor.
                    if (!pause_in) begin
                        if (y1_in && (y1_cnt != {CNT_W{1'b1}}))
                            y1_cnt <= y1_cnt + CNT_W'(1);
                        if (y2_in && (y2_cnt != {CNT_W{1'b1}}))
                            y2_cnt <= y2_cnt + CNT_W'(1);
                        if (tmr == TW'(HOLD_CYCLES - 1)) begin
                            tmr <= '0;
                            if (step_q == SW'(NUM_STEPS - 1)) begin
                                state    <= S_DONE;
                                done_out <= 1'b1;
                                busy_out <= 1'b0;
                            end else begin
                                step_q <= step_nxt;
`ifdef SEQ_STIM_LFSR_EN
                                lfsr           <= lfsr_nxt;
                                {a_out, b_out} <= lfsr_nxt[1:0];
`else
                                {a_out, b_out} <= step_nxt[1:0];
`endif
                            end
                        end else begin
                            tmr <= tmr + TW'(1);
                        end
                    end
                end
                S_DONE: begin
                    state           <= S_IDLE;
                    dut_reset_n_out <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_stim_driver.sv
// Bench for seq_stim_driver: a default instance and a short-run, 2-bit-counter instance,
// checked with a cycle table plus randomized runs against a step/count model.
module tb_seq_stim_driver;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start_m = 1'b0;
    logic       start_s = 1'b0;
    logic       pause = 1'b0;
    logic       y1 = 1'b0;
    logic       y2 = 1'b0;

    logic       m_rst_n, m_a, m_b, m_busy, m_done;
    logic [1:0] m_step;
    logic [7:0] m_c1, m_c2;
    logic       s_rst_n, s_a, s_b, s_busy, s_done;
    logic [1:0] s_step;
    logic [1:0] s_c1, s_c2;

    int checks = 0;
    int errors = 0;
    int held_ab[2];

    always #5 clk = ~clk;

    seq_stim_driver dut_m (
        .clk(clk), .reset_n(reset_n), .start_in(start_m), .pause_in(pause),
        .y1_in(y1), .y2_in(y2), .dut_reset_n_out(m_rst_n), .a_out(m_a), .b_out(m_b),
        .step_out(m_step), .busy_out(m_busy), .done_out(m_done),
        .y1_cnt_out(m_c1), .y2_cnt_out(m_c2)
    );

    seq_stim_driver #(.RST_CYCLES(1), .HOLD_CYCLES(1), .NUM_STEPS(6), .CNT_W(2)) dut_s (
        .clk(clk), .reset_n(reset_n), .start_in(start_s), .pause_in(pause),
        .y1_in(y1), .y2_in(y2), .dut_reset_n_out(s_rst_n), .a_out(s_a), .b_out(s_b),
        .step_out(s_step), .busy_out(s_busy), .done_out(s_done),
        .y1_cnt_out(s_c1), .y2_cnt_out(s_c2)
    );

    typedef struct {
        int start; int pause; int y1; int y2;
        int rn; int ab; int st; int bz; int dn; int c1; int c2;
    } vec_t;
    vec_t tbl[12];

    // Expected {a,b} for step s, counted from the start of a run.
    function automatic int pattern(input int s);
`ifdef SEQ_STIM_LFSR_EN
        int l = 9;
        for (int i = 0; i < s; i++)
            l = ((l << 1) & 15) | (((l >> 3) ^ (l >> 2)) & 1);
        return l & 3;
`else
        return s % 4;
`endif
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input int sel, input string tag, input int rn, input int ab,
                             input int st, input int bz, input int dn, input int c1, input int c2);
        if (sel == 0) begin
            check({tag, " rst_n"}, int'(m_rst_n), rn);
            check({tag, " ab"}, int'({m_a, m_b}), ab);
            check({tag, " step"}, int'(m_step), st);
            check({tag, " busy"}, int'(m_busy), bz);
            check({tag, " done"}, int'(m_done), dn);
            check({tag, " y1_cnt"}, int'(m_c1), c1);
            check({tag, " y2_cnt"}, int'(m_c2), c2);
        end else begin
            check({tag, " s.rst_n"}, int'(s_rst_n), rn);
            check({tag, " s.ab"}, int'({s_a, s_b}), ab);
            check({tag, " s.step"}, int'(s_step), st);
            check({tag, " s.busy"}, int'(s_busy), bz);
            check({tag, " s.done"}, int'(s_done), dn);
            check({tag, " s.y1_cnt"}, int'(s_c1), c1);
            check({tag, " s.y2_cnt"}, int'(s_c2), c2);
        end
    endtask

    task automatic set_start(input int sel, input logic v);
        if (sel == 0) start_m = v;
        else start_s = v;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One full run checked against the model: the sequence position is the number of
    // unpaused RUN cycles so far; step = that / hold; counts are saturating sums.
    task automatic run_one(input int sel, input int rc, input int hc, input int ns, input int cw,
                           input int pause_pct, input int force_k, input int noise, input int ytie);
        int maxc = (1 << cw) - 1;
        int k = 0, paused = 0, lat = 0, c1 = 0, c2 = 0, forced = 0, fired = 0, p = 0, s = 0;
        set_start(sel, 1'b1);
        pause = 1'($urandom_range(0, 1));
        tick();
        check_all(sel, "start", 0, held_ab[sel], 0, 1, 0, 0, 0);
        for (int i = 1; i <= rc; i++) begin
            set_start(sel, (noise != 0) ? 1'($urandom_range(0, 1)) : 1'b0);
            pause = 1'($urandom_range(0, 1));
            y1 = 1'($urandom_range(0, 1));
            y2 = 1'($urandom_range(0, 1));
            tick();
            lat++;
            if (i < rc) check_all(sel, "rst", 0, held_ab[sel], 0, 1, 0, 0, 0);
            else        check_all(sel, "rst_exit", 1, pattern(0), 0, 1, 0, 0, 0);
        end
        while (k < ns * hc && lat < 500) begin
            if (fired == 0 && force_k >= 0 && k == force_k) begin
                forced = 3;
                fired = 1;
            end
            if (forced > 0) begin
                p = 1;
                forced--;
            end else begin
                p = ($urandom_range(0, 99) < pause_pct) ? 1 : 0;
            end
            pause = 1'(p);
            set_start(sel, (noise != 0) ? 1'($urandom_range(0, 1)) : 1'b0);
            y1 = (ytie != 0) ? 1'b1 : 1'($urandom_range(0, 1));
            y2 = (ytie != 0) ? 1'b0 : 1'($urandom_range(0, 1));
            tick();
            lat++;
            if (p == 0) begin
                k++;
                c1 = (c1 + int'(y1) > maxc) ? maxc : c1 + int'(y1);
                c2 = (c2 + int'(y2) > maxc) ? maxc : c2 + int'(y2);
            end else begin
                paused++;
            end
            if (k == ns * hc) begin
                check_all(sel, "done", 1, pattern(ns - 1), (ns - 1) % 4, 0, 1, c1, c2);
            end else begin
                s = k / hc;
                check_all(sel, "run", 1, pattern(s), s % 4, 1, 0, c1, c2);
            end
        end
        check("latency", lat, rc + ns * hc + paused);
        set_start(sel, (noise != 0) ? 1'($urandom_range(0, 1)) : 1'b0);
        pause = 1'($urandom_range(0, 1));
        tick();
        check_all(sel, "idle", 0, pattern(ns - 1), (ns - 1) % 4, 0, 0, c1, c2);
        set_start(sel, 1'b0);
        tick();
        check_all(sel, "idle_hold", 0, pattern(ns - 1), (ns - 1) % 4, 0, 0, c1, c2);
        held_ab[sel] = pattern(ns - 1);
    endtask

    initial begin
        held_ab[0] = 0;
        held_ab[1] = 0;
        // Cycle table for a default run with y1 tied high; index i = inputs before edge i,
        // expectations after it. Edge 0 accepts start; pause/y2/start outside RUN are ignored.
        tbl[0]  = '{1, 0, 1, 1,  0, 0, 0, 1, 0, 0, 0};
        tbl[1]  = '{0, 1, 1, 1,  0, 0, 0, 1, 0, 0, 0};
        tbl[2]  = '{1, 1, 1, 1,  1, 0, 0, 1, 0, 0, 0};
        tbl[3]  = '{0, 0, 1, 0,  1, 0, 0, 1, 0, 1, 0};
        tbl[4]  = '{0, 0, 1, 0,  1, 1, 1, 1, 0, 2, 0};
        tbl[5]  = '{1, 0, 1, 0,  1, 1, 1, 1, 0, 3, 0};
        tbl[6]  = '{0, 0, 1, 0,  1, 2, 2, 1, 0, 4, 0};
        tbl[7]  = '{0, 0, 1, 0,  1, 2, 2, 1, 0, 5, 0};
        tbl[8]  = '{0, 0, 1, 0,  1, 3, 3, 1, 0, 6, 0};
        tbl[9]  = '{0, 0, 1, 0,  1, 3, 3, 1, 0, 7, 0};
        tbl[10] = '{0, 0, 1, 0,  1, 3, 3, 0, 1, 8, 0};
        tbl[11] = '{1, 1, 1, 1,  0, 3, 3, 0, 0, 8, 0};

        repeat (3) @(posedge clk);
        #1;
        check_all(0, "reset", 0, 0, 0, 0, 0, 0, 0);
        check_all(1, "reset", 0, 0, 0, 0, 0, 0, 0);
        reset_n = 1'b1;
        tick();
        check_all(0, "post_reset", 0, 0, 0, 0, 0, 0, 0);

`ifndef SEQ_STIM_LFSR_EN
        for (int i = 0; i < 12; i++) begin
            start_m = 1'(tbl[i].start);
            pause   = 1'(tbl[i].pause);
            y1      = 1'(tbl[i].y1);
            y2      = 1'(tbl[i].y2);
            tick();
            check_all(0, $sformatf("tbl[%0d]", i), tbl[i].rn, tbl[i].ab, tbl[i].st,
                      tbl[i].bz, tbl[i].dn, tbl[i].c1, tbl[i].c2);
        end
        start_m = 1'b0;
        tick();
        check_all(0, "tbl_hold", 0, 3, 3, 0, 0, 8, 0);
        held_ab[0] = 3;
`endif

        run_one(0, 2, 2, 4, 8, 0, -1, 0, 1);
        run_one(0, 2, 2, 4, 8, 0, 3, 0, 0);
        run_one(0, 2, 2, 4, 8, 30, -1, 1, 0);

        // Abort mid-run: reset must take effect without a clock edge.
        start_m = 1'b1;
        pause = 1'b0;
        y1 = 1'b1;
        tick();
        start_m = 1'b0;
        repeat (7) tick();
        check("pre_abort step", int'(m_step), 2);
        #2;
        reset_n = 1'b0;
        #1;
        check_all(0, "abort", 0, 0, 0, 0, 0, 0, 0);
        check_all(1, "abort", 0, 0, 0, 0, 0, 0, 0);
        tick();
        reset_n = 1'b1;
        held_ab[0] = 0;
        held_ab[1] = 0;
        run_one(0, 2, 2, 4, 8, 0, -1, 0, 0);

        run_one(1, 1, 1, 6, 2, 0, -1, 1, 1);
        run_one(1, 1, 1, 6, 2, 25, -1, 1, 0);
        run_one(1, 1, 1, 6, 2, 0, 2, 0, 1);
        for (int r = 0; r < 4; r++)
            run_one(0, 2, 2, 4, 8, $urandom_range(0, 50), -1, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
